// File: rtl/clk_div_pkg.sv
// Shared constants for the three-channel clock divider.
package clk_div_pkg;
    localparam int NCH       = 3;
    localparam int DIV_W_DEF = 28;
    localparam int DIV_STOP  = 0;
endpackage

// File: rtl/div_chan.sv
// One divider channel: up-counter, active/pending divisor, square wave and toggle tick.
module div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 15
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic             upd_acc,
    input  logic [DIV_W-1:0] upd_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pv
);
    localparam logic [DIV_W-1:0] DEF_Q  = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] STOP_Q = DIV_W'(DIV_STOP);

    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, pdiv_q, pdiv_d;
    logic             pv_q, pv_d, clk_q, clk_d, tick_q, tick_d;
    logic             wrap;

    assign wrap = (div_q != STOP_Q) && (cnt_q == div_q - DIV_W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pv_d   = pv_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (en_in) begin
            if (div_q == STOP_Q) begin
                // stopped channel picks up a pending divisor right away, restarting low
                cnt_d = '0;
                clk_d = 1'b0;
                if (pv_q) begin
                    div_d = pdiv_q;
                    pv_d  = 1'b0;
                end
            end else if (wrap) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                if (pv_q) begin
                    div_d = pdiv_q;
                    pv_d  = 1'b0;
                    if (pdiv_q == STOP_Q) clk_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
        // acceptance requires pv_q==0, so it never collides with an apply above
        if (upd_acc) begin
            pdiv_d = upd_div;
            pv_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= DEF_Q;
            pdiv_q <= '0;
            pv_q   <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pv_q   <= pv_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pv      = pv_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// Three independent clock dividers with a per-channel single-entry update handshake.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DEF_DIV0 = 15,
    parameter int DEF_DIV1 = 30,
    parameter int DEF_DIV2 = 60
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_sel,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic             busy
);
    logic [NCH-1:0] pv, acc;
    logic [3:0]     pv_ext;

    // sel==3 maps onto a permanently "pending" slot so it can never be accepted
    assign pv_ext    = {1'b1, pv};
    assign cfg_ready = (cfg_sel != 2'd3) && !pv_ext[cfg_sel];
    assign busy      = |pv;

    always_comb begin
        acc = '0;
        for (int i = 0; i < NCH; i++)
            acc[i] = cfg_valid && cfg_ready && (cfg_sel == 2'(i));
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam int DEF = (g == 0) ? DEF_DIV0 : (g == 1) ? DEF_DIV1 : DEF_DIV2;
        div_chan #(
            .DIV_W  (DIV_W),
            .DEF_DIV(DEF)
        ) u_chan (
            .clk_in (clk_in),
            .rst_n  (rst_n),
            .en_in  (en_in),
            .upd_acc(acc[g]),
            .upd_div(cfg_div),
            .clk_out(clk_out[g]),
            .tick   (tick[g]),
            .pv     (pv[g])
        );
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboarded random/directed bench for clk_div_ctrl against a countdown reference model.
module tb_clk_div_ctrl;
    localparam int DW = 28;

    logic          clk_in = 1'b0;
    logic          rst_n, en_in, cfg_valid, cfg_ready, busy;
    logic [1:0]    cfg_sel;
    logic [DW-1:0] cfg_div;
    logic [2:0]    clk_out, tick;

    clk_div_ctrl #(.DIV_W(DW), .DEF_DIV0(15), .DEF_DIV1(30), .DEF_DIV2(60)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .en_in(en_in), .cfg_valid(cfg_valid),
        .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
        .clk_out(clk_out), .tick(tick), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0] clk;
        logic [2:0] tck;
        logic       bsy;
        logic       rdy;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // reference: cycles left until next toggle, counted down from the divisor
    int defs[3] = '{15, 30, 60};
    int m_div[3], m_left[3], m_pdiv[3];
    bit m_lvl[3], m_tick[3], m_pv[3];

    function automatic void model_step();
        bit acc;
        acc = cfg_valid && (cfg_sel != 2'd3);
        if (acc) acc = !m_pv[cfg_sel];
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_div[i] = defs[i]; m_left[i] = defs[i]; m_lvl[i] = 0;
                m_tick[i] = 0; m_pv[i] = 0; m_pdiv[i] = 0;
            end else begin
                m_tick[i] = 0;
                if (en_in) begin
                    if (m_div[i] == 0) begin
                        if (m_pv[i]) begin
                            m_div[i] = m_pdiv[i]; m_pv[i] = 0; m_left[i] = m_div[i];
                        end
                    end else begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_lvl[i] = !m_lvl[i]; m_tick[i] = 1;
                            if (m_pv[i]) begin
                                m_div[i] = m_pdiv[i]; m_pv[i] = 0;
                                if (m_div[i] == 0) m_lvl[i] = 0;
                            end
                            m_left[i] = m_div[i];
                        end
                    end
                end
                if (acc && cfg_sel == 2'(i)) begin
                    m_pdiv[i] = int'(cfg_div); m_pv[i] = 1;
                end
            end
        end
    endfunction

    function automatic exp_t mk_exp();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.clk[i] = m_lvl[i];
            e.tck[i] = m_tick[i];
        end
        e.bsy = m_pv[0] | m_pv[1] | m_pv[2];
        e.rdy = (cfg_sel != 2'd3) && !m_pv[(cfg_sel == 2'd3) ? 0 : cfg_sel];
        return e;
    endfunction

    function automatic void chk(string nm, logic [2:0] act, logic [2:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, req);
        end
    endfunction

    // drive inputs for the coming edge, record the expectation, then advance the model over that edge
    task automatic cyc(input bit r, input bit e, input bit v, input logic [1:0] s, input int d);
        rst_n = r; en_in = e; cfg_valid = v; cfg_sel = s; cfg_div = DW'(d);
        sb.push_back(mk_exp());
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1, 1, 0, 2'd0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("clk_out", clk_out, e.clk);
                chk("tick", tick, e.tck);
                chk("busy", {2'b0, busy}, {2'b0, e.bsy});
                chk("cfg_ready", {2'b0, cfg_ready}, {2'b0, e.rdy});
            end
        end
    end

    initial begin : stim
        int k;
        rst_n = 0; en_in = 1; cfg_valid = 0; cfg_sel = 0; cfg_div = '0;
        @(posedge clk_in);
        model_step();
        #1;
        cyc(0, 1, 0, 2'd0, 0);
        idle(130);                       // default periods 30/60/120
        cyc(1, 1, 1, 2'd1, 10);          // ch1 -> 10 mid-period
        cyc(1, 1, 0, 2'd1, 0);           // ready for sel=1 must read low now
        idle(80);
        k = 0;
        while (!(m_left[0] == 1 && m_div[0] != 0 && !m_pv[0]) && k < 100) begin
            idle(1); k++;
        end
        cyc(1, 1, 1, 2'd0, 4);           // ch0 -> 4 on its wrap edge
        idle(40);
        cyc(1, 1, 1, 2'd2, 0);           // ch2 stop
        k = 0;
        while (m_pv[2] && k < 200) begin
            idle(1); k++;
        end
        idle(5);
        cyc(1, 1, 1, 2'd2, 5);           // ch2 restart at 5
        idle(40);
        for (int j = 0; j < 7; j++) cyc(1, 0, 1, 2'd3, 9);
        idle(30);
        cyc(1, 1, 1, 2'd1, 3);
        cyc(0, 1, 0, 2'd0, 0);           // reset with ch1 pending
        idle(70);
        for (int j = 0; j < 3000; j++) begin
            cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12)));
        end
        idle(1);
        @(negedge clk_in);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 28, meaning width of every divisor and counter.
REQ-002 SHALL have parameter DEF_DIV0, default 15, meaning channel 0 reset divisor.
REQ-003 SHALL have parameter DEF_DIV1, default 30, meaning channel 1 reset divisor.
REQ-004 SHALL have parameter DEF_DIV2, default 60, meaning channel 2 reset divisor.
REQ-005 SHALL have port clk_in  input  1  sole clock, 12 MHz board clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port en_in  input  1  global run enable; low freezes all channels.
REQ-008 SHALL have port cfg_valid  input  1  divisor update request.
REQ-009 SHALL have port cfg_sel  input  2  target channel 0..2; value 3 is invalid.
REQ-010 SHALL have port cfg_div  input  DIV_W  new divisor; 0 means channel stopped.
REQ-011 SHALL have port cfg_ready  output  1  update can be accepted for cfg_sel this cycle.
REQ-012 SHALL have port clk_out  output  3  per-channel divided square wave.
REQ-013 SHALL have port tick  output  3  per-channel one-cycle pulse on each clk_out toggle.
REQ-014 SHALL have port busy  output  1  any channel holds a pending update.

Function
REQ-015 Each channel SHALL keep a DIV_W-bit counter cnt, active divisor div, pending divisor pdiv and pending flag pv.
REQ-016 With en_in=1 and div>0, cnt SHALL increment each cycle; when cnt==div-1 (wrap), cnt SHALL return to 0, clk_out SHALL toggle and tick SHALL be 1 for that cycle only (registered, same edge as the toggle).
REQ-017 clk_out period SHALL be 2*div clk_in cycles, 50% duty; div=1 SHALL toggle every cycle.
REQ-018 With en_in=0, cnt, clk_out and div SHALL hold, tick SHALL be 0, pending updates SHALL not apply; handshake SHALL still accept.
REQ-019 div=0 SHALL hold cnt=0, clk_out=0, tick=0.
REQ-020 cfg_ready SHALL equal (cfg_sel!=3) AND NOT pv[cfg_sel] (combinational from cfg_sel and registered pv).
REQ-021 An update SHALL be accepted when cfg_valid AND cfg_ready; cfg_div goes to pdiv, pv set the next cycle.
REQ-022 A pending update SHALL apply on the channel's next wrap: div<=pdiv, cnt<=0, pv cleared; the toggle of that wrap still occurs.
REQ-023 If the channel's div==0, a pending update SHALL apply on the cycle after acceptance while en_in=1; clk_out starts low, first toggle after new div cycles.
REQ-024 Accepting pdiv=0 SHALL at the applying wrap force clk_out=0 and stop the channel.
REQ-025 Acceptance and wrap on the same cycle for the same channel SHALL store to pdiv and apply at the following wrap, never the current one.
REQ-026 cfg_sel=3 SHALL never be accepted; no state changes.
REQ-027 busy SHALL equal OR of pv[2:0].
REQ-028 Channels SHALL be fully independent; simultaneous wraps on several channels SHALL all be handled in the same cycle.

Reset
REQ-029 On rst_n=0 at a clk_in edge: cnt=0, clk_out=3'b000, tick=3'b000, pv=0, pdiv=0, div=DEF_DIV0/1/2, busy=0.
REQ-030 Reset asserted mid-period or with updates pending SHALL discard pending updates and restore default divisors; first toggles after release at cycle DEF_DIVn.

Structure
REQ-031 Package clk_div_pkg SHALL hold NCH=3, DIV_W default, and the stop-code constant DIV_STOP=0.
REQ-032 One sub-module div_chan SHALL implement one channel (cnt, div, pdiv, pv, clk_out, tick), instantiated three times; clk_div_ctrl holds cfg decode and busy.

Verification
REQ-033 Reset release, en_in=1, defaults -> clk_out[0]/[1]/[2] periods 30/60/120 cycles, tick pulses every 15/30/60 cycles, first at cycle 15/30/60.
REQ-034 Channel 1 write cfg_div=10 mid-period -> busy=1, cfg_ready(sel=1)=0, next wrap at old div=30, then period 20 cycles, busy=0.
REQ-035 Channel 0 write 4 on its exact wrap cycle -> one more 15-cycle half-period, then 4-cycle half-periods.
REQ-036 Channel 2 write 0, then 5 -> after next wrap clk_out[2]=0 held; write 5 applies next cycle, toggles every 5 cycles.
REQ-037 en_in low for 7 cycles mid-period -> all clk_out hold, tick=0, phase resumes with 7-cycle shift; cfg_sel=3 with cfg_valid -> cfg_ready=0, no change.
REQ-038 rst_n low 1 cycle with pending update on channel 1 -> pv cleared, channel 1 resumes div 30.
